// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared pipeline-control types, constants and hazard helper
package core_ctrl_pkg;

    // Divider sequencing state
    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    // Instruction word the stage registers load on a flush or bubble (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // True when the ID instruction reads the register a load in EX is about to write.
    // x0 is never a real dependency.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance monitoring
//
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset, clears the count
//   inc    count this cycle
//   count  current value; sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/bubble sequencer for the 5-stage core
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   rs1_id, rs2_id, rs1_used_id,
//   rs2_used_id                        source operands of the ID instruction
//   rd_ex, mem_read_ex                 destination / load flag of the EX instruction
//   div_req_ex, div_done               divide request in EX, divider completion pulse
//   branch_taken_ex, branch_target_ex  control-flow redirect from EX
//   icache_miss, dcache_miss           fetch not ready / MEM access not complete
//   stall_*                            hold the named pipeline register
//   flush_if_id, flush_id_ex           load NOP into IF/ID, ID/EX
//   bubble_ex_mem, bubble_mem_wb       load NOP into EX/MEM, MEM/WB
//   div_start                          one-cycle divider start
//   redirect_valid, redirect_pc        PC redirect
//   stall_cycles, flush_count          saturating performance counters
module hazard_control_unit
    import core_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             div_req_ex,
    input  logic             div_done,
    input  logic             branch_taken_ex,
    input  logic [XLEN-1:0]  branch_target_ex,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             bubble_mem_wb,
    output logic             div_start,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    div_state_e      state_q, state_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic freeze;
    logic div_stall;
    logic load_use;
    logic branch_live;

    assign freeze      = dcache_miss;
    assign div_stall   = ((state_q == DIV_IDLE) && div_req_ex) ||
                         ((state_q == DIV_BUSY) && !div_done);
    assign load_use    = load_use_hazard(rs1_id, rs2_id, rs1_used_id, rs2_used_id,
                                         rd_ex, mem_read_ex);
    assign branch_live = branch_taken_ex && !freeze;

    always_comb begin
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        bubble_ex_mem  = 1'b0;
        bubble_mem_wb  = 1'b0;
        div_start      = 1'b0;
        redirect_valid = 1'b0;
        state_d        = state_q;
        pend_d         = pend_q;
        pend_pc_d      = pend_pc_q;

        // A live branch always drives its own target, even over a pending one.
        redirect_pc = (pend_q && !branch_live) ? pend_pc_q : branch_target_ex;

        // Completion releases the divide in the same cycle; a completion seen
        // during a freeze is dropped, the divider keeps div_done high instead.
        if (!freeze && (state_q == DIV_BUSY) && div_done) begin
            state_d = DIV_IDLE;
        end

        if (freeze) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            stall_ex_mem  = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (div_stall) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            if (state_q == DIV_IDLE) begin
                div_start = 1'b1;
                state_d   = DIV_BUSY;
            end
        end else if (branch_taken_ex || pend_q) begin
            // IF/ID keeps flushing until the redirect is actually taken, so
            // wrong-path fetches returned by the miss never reach ID.
            flush_if_id = 1'b1;
            if (branch_taken_ex) begin
                flush_id_ex = 1'b1;
                pend_pc_d   = branch_target_ex;
                if (icache_miss) begin
                    pend_d = 1'b1;
                end else begin
                    redirect_valid = 1'b1;
                    pend_d         = 1'b0;
                end
            end else if (!icache_miss) begin
                redirect_valid = 1'b1;
                pend_d         = 1'b0;
            end
        end else if (load_use) begin
            // Also covers a concurrent I-miss: holding IF/ID wins over flushing it.
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (icache_miss) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_pc),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_id_ex),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, mem_read_ex;
    logic        div_req_ex, div_done, branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        icache_miss, dcache_miss;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        flush_if_id, flush_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic        div_start, redirect_valid;
    logic [31:0] redirect_pc, stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
    //  flush_id_ex, bubble_ex_mem, bubble_mem_wb, div_start, redirect_valid}
    logic [9:0] ctrl;
    assign ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
                   flush_id_ex, bubble_ex_mem, bubble_mem_wb, div_start, redirect_valid};

    localparam logic [9:0] C_NONE   = 10'b0000000000;
    localparam logic [9:0] C_LU     = 10'b1100010000;
    localparam logic [9:0] C_IMISS  = 10'b1000100000;
    localparam logic [9:0] C_DIVST  = 10'b1110001010;
    localparam logic [9:0] C_DIVBSY = 10'b1110001000;
    localparam logic [9:0] C_FREEZE = 10'b1111000100;
    localparam logic [9:0] C_BRMISS = 10'b0000110000;
    localparam logic [9:0] C_PEND   = 10'b0000100000;
    localparam logic [9:0] C_PENDGO = 10'b0000100001;
    localparam logic [9:0] C_BRGO   = 10'b0000110001;

    hazard_control_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .rs1_used_id      (rs1_used_id),
        .rs2_used_id      (rs2_used_id),
        .rd_ex            (rd_ex),
        .mem_read_ex      (mem_read_ex),
        .div_req_ex       (div_req_ex),
        .div_done         (div_done),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .icache_miss      (icache_miss),
        .dcache_miss      (dcache_miss),
        .stall_pc         (stall_pc),
        .stall_if_id      (stall_if_id),
        .stall_id_ex      (stall_id_ex),
        .stall_ex_mem     (stall_ex_mem),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .bubble_ex_mem    (bubble_ex_mem),
        .bubble_mem_wb    (bubble_mem_wb),
        .div_start        (div_start),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        div_req_ex = 1'b0; div_done = 1'b0; branch_taken_ex = 1'b0;
        branch_target_ex = 32'h0; icache_miss = 1'b0; dcache_miss = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        mem_read_ex = 1'b1; rd_ex = rd;
        rs1_id = rs1; rs1_used_id = u1;
        rs2_id = rs2; rs2_used_id = u2;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        settle();
        check("reset_ctrl", ctrl, C_NONE);
        check("reset_rpc", redirect_pc, 32'h0);
        check("reset_stall_cnt", stall_cycles, 0);
        check("reset_flush_cnt", flush_count, 0);
        tick();

        // Load-use on rs1
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        settle(); check("lu_rs1", ctrl, C_LU); tick();
        idle_inputs(); settle();
        check("lu_stall_cnt", stall_cycles, 1);
        check("lu_after", ctrl, C_NONE);
        // rd = x0 never hazards
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        settle(); check("lu_x0", ctrl, C_NONE); tick();
        // rs2 hit, then rs2 not used
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        settle(); check("lu_rs2", ctrl, C_LU); tick();
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        settle(); check("lu_rs2_unused", ctrl, C_NONE); tick();
        // Load-use with I-miss: IF/ID held, not flushed
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); icache_miss = 1'b1;
        settle(); check("lu_imiss", ctrl, C_LU); tick();
        idle_inputs(); icache_miss = 1'b1;
        settle(); check("imiss_alone", ctrl, C_IMISS); tick();
        idle_inputs(); settle();
        check("grp1_stall_cnt", stall_cycles, 4);
        check("grp1_flush_cnt", flush_count, 3);

        // Divide: start, 7 busy cycles, done on the 8th cycle after start
        div_req_ex = 1'b1;
        settle(); check("div_start", ctrl, C_DIVST); tick();
        for (int i = 1; i < 8; i++) begin
            settle(); check($sformatf("div_busy%0d", i), ctrl, C_DIVBSY); tick();
        end
        div_done = 1'b1;
        settle(); check("div_release", ctrl, C_NONE); tick();
        idle_inputs(); settle();
        check("div_stall_cnt", stall_cycles, 12);
        // div_done in IDLE is ignored
        div_done = 1'b1;
        settle(); check("div_done_idle", ctrl, C_NONE); tick();

        // Freeze during divide: start, busy, 3 frozen cycles (done arrives in last)
        idle_inputs(); div_req_ex = 1'b1;
        settle(); check("fz_div_start", ctrl, C_DIVST); tick();
        settle(); check("fz_busy", ctrl, C_DIVBSY); tick();
        dcache_miss = 1'b1;
        settle(); check("fz_0", ctrl, C_FREEZE); tick();
        settle(); check("fz_1", ctrl, C_FREEZE); tick();
        div_done = 1'b1;
        settle(); check("fz_2_done", ctrl, C_FREEZE); tick();
        dcache_miss = 1'b0;
        settle(); check("fz_release", ctrl, C_NONE); tick();
        idle_inputs(); settle();
        check("fz_stall_cnt", stall_cycles, 17);

        // Redirect during I-miss
        branch_taken_ex = 1'b1; branch_target_ex = 32'h00000400; icache_miss = 1'b1;
        settle(); check("br_miss", ctrl, C_BRMISS); tick();
        branch_taken_ex = 1'b0; branch_target_ex = 32'h00000999;
        for (int i = 1; i < 4; i++) begin
            settle(); check($sformatf("pend%0d", i), ctrl, C_PEND); tick();
        end
        icache_miss = 1'b0;
        settle();
        check("pend_go", ctrl, C_PENDGO);
        check("pend_go_pc", redirect_pc, 32'h00000400);
        tick();
        branch_target_ex = 32'h00000777;
        settle();
        check("pend_clear", ctrl, C_NONE);
        check("pend_clear_pc", redirect_pc, 32'h00000777);
        tick();

        // New branch overwrites a pending target
        idle_inputs();
        branch_taken_ex = 1'b1; branch_target_ex = 32'h00000100; icache_miss = 1'b1;
        settle(); check("ow_first", ctrl, C_BRMISS); tick();
        branch_target_ex = 32'h00000200;
        settle(); check("ow_second", ctrl, C_BRMISS); tick();
        idle_inputs();
        settle();
        check("ow_go", ctrl, C_PENDGO);
        check("ow_go_pc", redirect_pc, 32'h00000200);
        tick();

        // Branch beats load-use
        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        branch_taken_ex = 1'b1; branch_target_ex = 32'h00000800;
        settle();
        check("br_lu", ctrl, C_BRGO);
        check("br_lu_pc", redirect_pc, 32'h00000800);
        tick();
        idle_inputs(); settle();
        check("end_stall_cnt", stall_cycles, 17);
        check("end_flush_cnt", flush_count, 7);

        // Reset mid-divide
        div_req_ex = 1'b1;
        settle(); check("rst_div_start", ctrl, C_DIVST); tick();
        tick();
        idle_inputs(); rst_n = 1'b0; tick();
        rst_n = 1'b1; settle();
        check("rst_ctrl", ctrl, C_NONE);
        check("rst_stall_cnt", stall_cycles, 0);
        check("rst_flush_cnt", flush_count, 0);
        tick();
        div_req_ex = 1'b1;
        settle(); check("rst_idle_start", ctrl, C_DIVST); tick();
        idle_inputs(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central pipeline sequencer for the 5-stage core. It sits beside the operand-bypass logic and owns every stall, flush and bubble enable for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- It resolves four hazards: load-use, the multi-cycle divider, taken-branch redirects and cache misses.
- It buffers a redirect that arrives during an I-cache miss, and it counts stall and flush cycles for performance monitoring.

Parameters:
- XLEN, 32, width of the PC and redirect target.
- CNT_W, 32, width of the performance counters (the counters saturate).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- rs1_id, rs2_id  in  5 each  source register addresses of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- mem_read_ex  in  1  the EX instruction is a load.
- div_req_ex  in  1  the EX instruction is a valid DIV/DIVU/REM/REMU.
- div_done  in  1  one-cycle pulse from the divider when the result is ready.
- branch_taken_ex  in  1  the EX instruction redirects control flow.
- branch_target_ex  in  XLEN  redirect target for that instruction.
- icache_miss  in  1  level signal; high while the fetch is not ready.
- dcache_miss  in  1  level signal; high while the MEM access is not complete.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the named register.
- flush_if_id, flush_id_ex  out  1 each  load a NOP into the named register.
- bubble_ex_mem, bubble_mem_wb  out  1 each  load a NOP into the named register.
- div_start  out  1  one-cycle start pulse to the divider.
- redirect_valid  out  1  the PC loads redirect_pc this cycle.
- redirect_pc  out  XLEN  redirect target.
- stall_cycles, flush_count  out  CNT_W each  performance counters.

Behaviour:
- Reset: when rst_n is low at a rising edge, all state clears:
  - div FSM goes to IDLE;
  - pend_q and pend_pc_q go to 0;
  - both counters go to 0.
  - With state cleared and inputs low, every output is 0.
- All control outputs are combinational from the inputs and the registered state; there is no added latency.
- Invariant: a stall and a flush (or a stall and a bubble) on the same register are never asserted together.
- Priority 1, freeze (dcache_miss = 1):
  - stall_pc, stall_if_id, stall_id_ex and stall_ex_mem = 1; bubble_mem_wb = 1.
  - All flushes, div_start and redirect_valid = 0.
  - FSM state and pend_q hold.
- Priority 2, divider FSM (IDLE / BUSY):
  - IDLE with div_req_ex and no freeze: div_start = 1, go to BUSY.
  - Stall condition: (IDLE && div_req_ex) or (BUSY && !div_done).
  - While the stall condition holds: stall_pc, stall_if_id, stall_id_ex = 1 and bubble_ex_mem = 1.
  - BUSY with div_done: release all stalls in that same cycle (the divide instruction advances), go to IDLE.
  - div_done seen in IDLE is ignored.
  - div_done arriving during a freeze is not held; the divider must keep div_done asserted until the freeze drops.
- Priority 3, redirect (branch_taken_ex with no freeze; the divider never coincides with a branch):
  - flush_if_id = 1 and flush_id_ex = 1.
  - If icache_miss = 0: redirect_valid = 1 and redirect_pc = branch_target_ex.
  - If icache_miss = 1: set pend_q = 1 and pend_pc_q = branch_target_ex; redirect_valid = 0.
- Pending redirect (pend_q = 1):
  - flush_if_id = 1 every cycle.
  - On the first cycle with icache_miss = 0 and no freeze: redirect_valid = 1, redirect_pc = pend_pc_q, then clear pend_q.
  - A new branch_taken_ex while pend_q = 1 overwrites pend_pc_q. If icache_miss = 0 it is emitted directly.
  - While pend_q = 0, redirect_pc = branch_target_ex.
- Priority 4, load-use:
  - Condition: mem_read_ex && rd_ex != 0 && ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex)).
  - Response: stall_pc = 1, stall_if_id = 1, flush_id_ex = 1.
  - Suppressed by priorities 1–3.
- Priority 5, icache_miss alone:
  - stall_pc = 1, flush_if_id = 1.
  - If load-use is also active: stall_if_id = 1 wins and flush_if_id = 0.
- Counters:
  - stall_cycles increments on every cycle with stall_pc = 1.
  - flush_count increments on every cycle with flush_id_ex = 1.
  - Both saturate at all-ones.

Decomposition:
- Shared package core_ctrl_pkg holds the div FSM state encoding (IDLE = 0, BUSY = 1) and the NOP encoding 32'h00000013 used by the stage registers.
- One sub-module, sat_counter (parameter CNT_W, inputs clk, rst_n, inc), instantiated twice.

Test Plan:
- Load-use: rd_ex = 5, mem_read_ex = 1, rs1_id = 5, rs1_used_id = 1 -> stall_pc = 1, stall_if_id = 1, flush_id_ex = 1 for one cycle; stall_cycles becomes 1. Repeat with rd_ex = 0 -> no stall.
- Divide: div_req_ex = 1, div_done pulsed 8 cycles later -> div_start = 1 in the first cycle only; stall plus bubble_ex_mem for 8 cycles; released in the div_done cycle; FSM back in IDLE.
- Freeze during divide: dcache_miss high for 3 cycles at cycle 2 of the divide -> all four stalls plus bubble_mem_wb for those cycles; no second div_start.
- Redirect during I-miss: branch_taken_ex = 1, target 32'h00000400, icache_miss = 1 for 4 cycles -> redirect_valid = 0 and flush_if_id = 1 throughout; redirect_valid = 1 with redirect_pc = 32'h00000400 on the cycle icache_miss falls; pend_q clears.
- Simultaneous branch and load-use -> flush_if_id = flush_id_ex = 1, stall_pc = 0, redirect_valid = 1.
- Reset mid-divide (rst_n low for 1 cycle while BUSY) -> FSM IDLE, counters 0, all outputs 0 while inputs are low.
